// File: rtl/pe_mac_sequencer_if.sv
// Bus between the layer scheduler / writeback path and pe_mac_sequencer:
// job configuration, buffer read port, PE partial sum and result handshake.
interface pe_mac_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 40
);
    // Job request and configuration
    logic                     start;
    logic [ADDR_W-1:0]        ifm_base;
    logic [ADDR_W-1:0]        wgt_base;
    logic [LEN_W-1:0]         num_groups;
    logic signed [ACC_W-1:0]  bias;
    logic                     relu_en;

    // Buffer read strobes and addresses
    logic                     ifm_rd_en;
    logic                     wgt_rd_en;
    logic [ADDR_W-1:0]        ifm_rd_addr;
    logic [ADDR_W-1:0]        wgt_rd_addr;

    // PE partial sum (3-register pipeline output)
    logic signed [24:0]       pe_psum;

    // Result handshake and status
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     busy;
    logic                     done;

    // Environment side: scheduler, buffers/PE and writeback
    modport master (
        output start, ifm_base, wgt_base, num_groups, bias, relu_en,
        output pe_psum, out_ready,
        input  ifm_rd_en, wgt_rd_en, ifm_rd_addr, wgt_rd_addr,
        input  out_valid, out_data, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, ifm_base, wgt_base, num_groups, bias, relu_en,
        input  pe_psum, out_ready,
        output ifm_rd_en, wgt_rd_en, ifm_rd_addr, wgt_rd_addr,
        output out_valid, out_data, busy, done
    );
endinterface

// File: rtl/pe_mac_sequencer.sv
// Sequences one output pixel's dot product through a 4-lane PE: issues N
// buffer reads, tracks which PE cycles carry valid partial sums, accumulates
// them onto a bias, applies optional ReLU and presents the result.
module pe_mac_sequencer #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    pe_mac_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        n_q, n_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    relu_q, relu_d;
    logic [ADDR_W-1:0]       ifm_addr_q, ifm_addr_d;
    logic [ADDR_W-1:0]       wgt_addr_q, wgt_addr_d;
    logic                    rd_en_q, rd_en_d;
    // Bit 0 = read issued last cycle; bit 3 = matching pe_psum is valid now
    logic [3:0]              vld_q, vld_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] acc_sum;

    // ReLU only touches the presented value, never the accumulator
    function automatic logic signed [ACC_W-1:0] relu_fn(
        input logic signed [ACC_W-1:0] v,
        input logic                    en
    );
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

    // Sign-extended partial sum and the accumulator value after this cycle
    always_comb begin
        psum_ext = {{(ACC_W-25){bus.pe_psum[24]}}, bus.pe_psum};
        acc_sum  = vld_q[3] ? (acc_q + psum_ext) : acc_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        relu_d      = relu_q;
        ifm_addr_d  = ifm_addr_q;
        wgt_addr_d  = wgt_addr_q;
        rd_en_d     = 1'b0;
        vld_d       = {vld_q[2:0], rd_en_q};
        acc_d       = acc_sum;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d        = bus.num_groups;
                    relu_d     = bus.relu_en;
                    acc_d      = bus.bias;
                    cnt_d      = '0;
                    ifm_addr_d = bus.ifm_base;
                    wgt_addr_d = bus.wgt_base;
                    if (bus.num_groups != '0) begin
                        state_d = ISSUE;
                        rd_en_d = 1'b1;
                    end else begin
                        // Nothing to accumulate: present the bias directly
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = relu_fn(bus.bias, bus.relu_en);
                    end
                end
            end
            ISSUE: begin
                // cnt_q is the group whose read is on the bus this cycle
                if (cnt_q == n_q - LEN_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d      = cnt_q + LEN_W'(1);
                    ifm_addr_d = ifm_addr_q + ADDR_W'(1);
                    wgt_addr_d = wgt_addr_q + ADDR_W'(1);
                    rd_en_d    = 1'b1;
                end
            end
            DRAIN: begin
                // Only the last valid bit remains: it is accumulated this edge
                if (vld_q[2:0] == 3'b000) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = relu_fn(acc_sum, relu_q);
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            relu_q      <= 1'b0;
            ifm_addr_q  <= '0;
            wgt_addr_q  <= '0;
            rd_en_q     <= 1'b0;
            vld_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            relu_q      <= relu_d;
            ifm_addr_q  <= ifm_addr_d;
            wgt_addr_q  <= wgt_addr_d;
            rd_en_q     <= rd_en_d;
            vld_q       <= vld_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.ifm_rd_en   = rd_en_q;
    assign bus.wgt_rd_en   = rd_en_q;
    assign bus.ifm_rd_addr = ifm_addr_q;
    assign bus.wgt_rd_addr = wgt_addr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Self-checking bench for pe_mac_sequencer: table of directed jobs with
// hand-computed results, plus sequences for backpressure and mid-job reset.
module tb_pe_mac_sequencer;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pe_mac_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus();

    pe_mac_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string  name;
        int     n;
        longint bias;
        bit     relu;
        int     ifm_base;
        int     wgt_base;
        int     psum [4];
        longint exp_out;
    } vec_t;

    vec_t vecs [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input int n, input longint bias, input bit relu,
                           input int ib, input int wb, input int p0, input int p1,
                           input int p2, input int p3, input longint exp_out);
        vec_t v;
        v.name = name; v.n = n; v.bias = bias; v.relu = relu;
        v.ifm_base = ib; v.wgt_base = wb;
        v.psum[0] = p0; v.psum[1] = p1; v.psum[2] = p2; v.psum[3] = p3;
        v.exp_out = exp_out;
        vecs.push_back(v);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " busy"},        longint'(bus.busy), 0);
        chk({tag, " done"},        longint'(bus.done), 0);
        chk({tag, " out_valid"},   longint'(bus.out_valid), 0);
        chk({tag, " ifm_rd_en"},   longint'(bus.ifm_rd_en), 0);
        chk({tag, " wgt_rd_en"},   longint'(bus.wgt_rd_en), 0);
        chk({tag, " ifm_rd_addr"}, longint'(bus.ifm_rd_addr), 0);
        chk({tag, " wgt_rd_addr"}, longint'(bus.wgt_rd_addr), 0);
        chk({tag, " out_data"},    longint'($signed(bus.out_data)), 0);
    endtask

    // Starts a job in the current (IDLE) cycle, drives pe_psum on its
    // scheduled cycles (5+k) with garbage elsewhere, accepts the result at
    // once and returns positioned in the done cycle.
    task automatic run_job(input vec_t v);
        int c;
        int strobes;
        bit seen;
        int exp_cyc;
        bus.start      = 1'b1;
        bus.num_groups = LEN_W'(v.n);
        bus.bias       = ACC_W'(v.bias);
        bus.relu_en    = v.relu;
        bus.ifm_base   = ADDR_W'(v.ifm_base);
        bus.wgt_base   = ADDR_W'(v.wgt_base);
        bus.out_ready  = 1'b1;
        bus.pe_psum    = 25'sd7777;
        tick;
        // Scramble config so anything not latched at start shows up
        bus.start      = 1'b0;
        bus.num_groups = 8'd200;
        bus.bias       = 40'sd12345;
        bus.relu_en    = ~v.relu;
        bus.ifm_base   = 10'd777;
        bus.wgt_base   = 10'd333;
        c = 1;
        strobes = 0;
        seen = 1'b0;
        exp_cyc = (v.n == 0) ? 1 : v.n + 5;
        while (c < 100 && !seen) begin
            if (c >= 5 && (c - 5) < v.n && (c - 5) < 4) bus.pe_psum = 25'(v.psum[c-5]);
            else bus.pe_psum = 25'sd7777;
            chk($sformatf("%s ifm_rd_en c%0d", v.name, c), longint'(bus.ifm_rd_en), longint'(c <= v.n));
            chk($sformatf("%s wgt_rd_en c%0d", v.name, c), longint'(bus.wgt_rd_en), longint'(c <= v.n));
            if (bus.ifm_rd_en) begin
                strobes++;
                chk($sformatf("%s ifm_rd_addr c%0d", v.name, c), longint'(bus.ifm_rd_addr),
                    longint'((v.ifm_base + c - 1) % 1024));
                chk($sformatf("%s wgt_rd_addr c%0d", v.name, c), longint'(bus.wgt_rd_addr),
                    longint'((v.wgt_base + c - 1) % 1024));
            end
            chk($sformatf("%s busy c%0d", v.name, c), longint'(bus.busy), 1);
            chk($sformatf("%s done c%0d", v.name, c), longint'(bus.done), 0);
            if (bus.out_valid) begin
                seen = 1'b1;
                chk($sformatf("%s out_valid cycle", v.name), c, exp_cyc);
                chk($sformatf("%s out_data", v.name), longint'($signed(bus.out_data)), v.exp_out);
            end
            tick;
            c++;
        end
        chk($sformatf("%s out_valid seen before timeout", v.name), longint'(seen), 1);
        chk($sformatf("%s strobe count", v.name), strobes, v.n);
        chk($sformatf("%s done pulse", v.name), longint'(bus.done), 1);
        chk($sformatf("%s busy low in done cycle", v.name), longint'(bus.busy), 0);
        chk($sformatf("%s out_valid dropped", v.name), longint'(bus.out_valid), 0);
        $display("job %s: N=%0d out_data=%0d valid at cycle %0d", v.name, v.n,
                 $signed(bus.out_data), c - 1);
    endtask

    initial begin
        vec_t v;
        int c;
        bit seen;

        bus.start = 1'b0; bus.ifm_base = '0; bus.wgt_base = '0; bus.num_groups = '0;
        bus.bias = '0; bus.relu_en = 1'b0; bus.pe_psum = '0; bus.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick;
        check_reset_vals("reset");
        $display("reset: outputs checked");
        rst_n = 1'b1;
        tick;

        //       name         N  bias        relu ifm   wgt  psum0      psum1      psum2      psum3      expected
        add_vec("basic_sum",  2, 10,         0,   0,    0,   100,       -30,       0,         0,         80);
        add_vec("relu_on",    1, 0,          1,   20,   40,  -50,       0,         0,         0,         0);
        add_vec("relu_off",   1, 0,          0,   20,   40,  -50,       0,         0,         0,         -50);
        add_vec("relu_bias",  1, 60,         1,   20,   40,  -50,       0,         0,         0,         10);
        add_vec("zero_len",   0, -5,         0,   9,    9,   0,         0,         0,         0,         -5);
        add_vec("zero_relu",  0, -5,         1,   9,    9,   0,         0,         0,         0,         0);
        add_vec("addr_wrap",  3, 0,          0,   1023, 5,   1,         2,         3,         0,         6);
        add_vec("psum_min",   4, -1,         0,   100,  200, -16777216, -16777216, -16777216, -16777216, -67108865);
        add_vec("psum_max",   4, 0,          1,   100,  200, 16777215,  16777215,  16777215,  16777215,  67108860);

        // Jobs run back to back: each start lands in the previous done cycle
        foreach (vecs[i]) run_job(vecs[i]);

        // Backpressure: N=1, bias 7, psum 3 -> 10, out_ready low, start pulsed
        bus.start = 1'b1; bus.num_groups = 8'd1; bus.bias = 40'sd7; bus.relu_en = 1'b0;
        bus.ifm_base = 10'd0; bus.wgt_base = 10'd0; bus.out_ready = 1'b0; bus.pe_psum = 25'sd7777;
        tick;
        bus.start = 1'b0;
        c = 1;
        seen = 1'b0;
        while (c < 100 && !seen) begin
            bus.pe_psum = (c == 5) ? 25'sd3 : 25'sd7777;
            if (bus.out_valid) seen = 1'b1;
            else begin
                tick;
                c++;
            end
        end
        chk("bp out_valid seen before timeout", longint'(seen), 1);
        chk("bp out_valid cycle", c, 6);
        bus.num_groups = 8'd0; bus.bias = 40'sd99;
        for (int h = 0; h < 6; h++) begin
            bus.start = (h % 2 == 0);
            bus.pe_psum = 25'sd1234;
            chk($sformatf("bp hold%0d out_valid", h), longint'(bus.out_valid), 1);
            chk($sformatf("bp hold%0d out_data", h), longint'($signed(bus.out_data)), 10);
            chk($sformatf("bp hold%0d ifm_rd_en", h), longint'(bus.ifm_rd_en), 0);
            chk($sformatf("bp hold%0d busy", h), longint'(bus.busy), 1);
            chk($sformatf("bp hold%0d done", h), longint'(bus.done), 0);
            tick;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp out_data at handshake", longint'($signed(bus.out_data)), 10);
        tick;
        chk("bp done pulse", longint'(bus.done), 1);
        chk("bp out_valid dropped", longint'(bus.out_valid), 0);
        $display("job backpressure: out_data held at 10 for 6 cycles");
        // Start in the done cycle: first read expected one cycle later at 50
        add_vec("after_bp",   2, 0,          0,   50,   60,  5,         6,         0,         0,         11);
        run_job(vecs[vecs.size()-1]);

        // Reset in cycle 3 of an N=8 job
        bus.start = 1'b1; bus.num_groups = 8'd8; bus.bias = 40'sd1000; bus.relu_en = 1'b0;
        bus.ifm_base = 10'd100; bus.wgt_base = 10'd100; bus.pe_psum = 25'sd7777;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        chk("midrst reading in cycle 3", longint'(bus.ifm_rd_en), 1);
        rst_n = 1'b0;
        tick;
        check_reset_vals("midrst");
        rst_n = 1'b1;
        for (int g = 0; g < 6; g++) begin
            bus.pe_psum = 25'sd7777;
            chk($sformatf("midrst idle%0d done", g), longint'(bus.done), 0);
            chk($sformatf("midrst idle%0d out_valid", g), longint'(bus.out_valid), 0);
            tick;
        end
        $display("job mid_reset: aborted N=8 job");
        add_vec("post_reset", 1, 0,          0,   0,    0,   42,        0,         0,         0,         42);
        run_job(vecs[vecs.size()-1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
